// File: rtl/cpu_pkg.sv
// Shared constants and types for the 16-bit five-stage pipeline.
// Holds opcode encodings, halt FSM states and the IF/ID field pre-decoder.
package cpu_pkg;

  localparam logic [3:0] OP_SW  = 4'b1001;
  localparam logic [3:0] OP_LLB = 4'b1010;
  localparam logic [3:0] OP_LHB = 4'b1011;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [15:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } ifid_state_e;

  typedef struct packed {
    logic [3:0] rd;
    logic [3:0] rs;
    logic [3:0] rt;
  } ifid_regs_t;

  // SW reads its data register from [11:8]; LLB/LHB modify [11:8] in place.
  function automatic ifid_regs_t predecode(
    input logic [15:0] instr,
    input logic        valid
  );
    ifid_regs_t f;
    logic [3:0] op;
    op   = instr[15:12];
    f.rd = instr[11:8];
    f.rs = instr[7:4];
    f.rt = instr[3:0];
    unique case (1'b1)
      op == OP_SW: f.rt = instr[11:8];
      (op == OP_LLB) || (op == OP_LHB): f.rs = instr[11:8];
      default: ;
    endcase
    if (!valid) f = '0;
    return f;
  endfunction

endpackage

// File: rtl/ifid_halt_fsm.sv
// Halt-drain controller: stops fetch on HLT, counts the pipeline empty,
// then parks in HALTED until reset.
module ifid_halt_fsm
  import cpu_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_stall,
  input  logic i_flush,
  input  logic i_load_hlt,
  output logic o_run,
  output logic o_pc_write,
  output logic o_halted
);

  localparam int CW = $clog2(DRAIN_CYCLES + 1);

  ifid_state_e r_state;
  ifid_state_e w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic r_halted;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_pc_write  = 1'b0;
    unique case (r_state)
      RUN: begin
        o_pc_write = !i_stall && !i_load_hlt;
        if (i_load_hlt) begin
          w_state_nxt = DRAIN;
          w_cnt_nxt   = CW'(DRAIN_CYCLES);
        end
      end
      DRAIN: begin
        // A flushed HLT was speculative: resume fetching.
        if (i_flush) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CW'(1)) begin
          w_state_nxt = HALTED;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      HALTED: ;
      default: begin
        w_state_nxt = RUN;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= RUN;
      r_cnt    <= '0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_halted <= (w_state_nxt == HALTED);
    end
  end

  assign o_run    = (r_state == RUN);
  assign o_halted = r_halted;

endmodule

// File: rtl/if_id_register.sv
// IF/ID pipeline register with field pre-decode and halt drain.
// Define IFID_PERF_CNT_EN to add stall/flush/instruction counters.
module if_id_register
  import cpu_pkg::*;
#(
  parameter int         DRAIN_CYCLES = 3,
  parameter logic [3:0] HALT_OPCODE  = OP_HLT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [15:0] instr_in,
  input  logic [15:0] pc_plus2_in,
  output logic [15:0] instr_out,
  output logic [15:0] pc_plus2_out,
  output logic        valid_out,
  output logic [3:0]  IFID_RegRs,
  output logic [3:0]  IFID_RegRt,
  output logic [3:0]  IFID_RegRd,
  output logic        pc_write,
  output logic        halted
`ifdef IFID_PERF_CNT_EN
  ,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count,
  output logic [15:0] instr_count
`endif
);

  logic [15:0] r_instr;
  logic [15:0] r_pc;
  logic        r_valid;
  logic        w_run;
  logic        w_halted;
  logic        w_flush;
  logic        w_load;
  logic        w_load_hlt;
  ifid_regs_t  w_regs;

  // HALTED ignores flush; any non-RUN state freezes the register.
  assign w_flush    = flush && !w_halted;
  assign w_load     = w_run && !stall && !flush;
  assign w_load_hlt = w_load && (instr_in[15:12] == HALT_OPCODE);

  ifid_halt_fsm #(
    .DRAIN_CYCLES(DRAIN_CYCLES)
  ) u_halt_fsm (
    .clk       (clk),
    .rst       (rst),
    .i_stall   (stall),
    .i_flush   (w_flush),
    .i_load_hlt(w_load_hlt),
    .o_run     (w_run),
    .o_pc_write(pc_write),
    .o_halted  (w_halted)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr <= NOP_INSTR;
      r_pc    <= 16'h0000;
      r_valid <= 1'b0;
    end else if (w_flush) begin
      r_instr <= NOP_INSTR;
      r_pc    <= 16'h0000;
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_instr <= instr_in;
      r_pc    <= pc_plus2_in;
      r_valid <= 1'b1;
    end
  end

  assign w_regs = predecode(r_instr, r_valid);

  assign instr_out    = r_instr;
  assign pc_plus2_out = r_pc;
  assign valid_out    = r_valid;
  assign IFID_RegRd   = w_regs.rd;
  assign IFID_RegRs   = w_regs.rs;
  assign IFID_RegRt   = w_regs.rt;
  assign halted       = w_halted;

`ifdef IFID_PERF_CNT_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;
  logic [15:0] r_instr_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_instr_cnt <= '0;
    end else if (!w_halted) begin
      if (w_run && stall) r_stall_cnt <= r_stall_cnt + 16'd1;
      if (w_flush)        r_flush_cnt <= r_flush_cnt + 16'd1;
      if (w_load)         r_instr_cnt <= r_instr_cnt + 16'd1;
    end
  end

  assign stall_count = r_stall_cnt;
  assign flush_count = r_flush_cnt;
  assign instr_count = r_instr_cnt;
`endif

endmodule

// File: tb/tb_if_id_register.sv
// Scoreboard bench for if_id_register: stimulus queues expectations,
// a monitor pops and compares them each cycle.
module tb_if_id_register;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [15:0] instr_in;
  logic [15:0] pc_plus2_in;
  logic [15:0] instr_out;
  logic [15:0] pc_plus2_out;
  logic        valid_out;
  logic [3:0]  IFID_RegRs;
  logic [3:0]  IFID_RegRt;
  logic [3:0]  IFID_RegRd;
  logic        pc_write;
  logic        halted;
`ifdef IFID_PERF_CNT_EN
  logic [15:0] stall_count;
  logic [15:0] flush_count;
  logic [15:0] instr_count;
`endif

  always #5 clk = ~clk;

  if_id_register dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .instr_in    (instr_in),
    .pc_plus2_in (pc_plus2_in),
    .instr_out   (instr_out),
    .pc_plus2_out(pc_plus2_out),
    .valid_out   (valid_out),
    .IFID_RegRs  (IFID_RegRs),
    .IFID_RegRt  (IFID_RegRt),
    .IFID_RegRd  (IFID_RegRd),
    .pc_write    (pc_write),
    .halted      (halted)
`ifdef IFID_PERF_CNT_EN
    ,
    .stall_count (stall_count),
    .flush_count (flush_count),
    .instr_count (instr_count)
`endif
  );

  typedef struct {
    string       nm;
    logic [15:0] ins;
    logic [15:0] pc;
    logic        v;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic        pcw;
    logic        h;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int pending = 0;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // pc_write is sampled before the edge, registered outputs after it.
  initial begin : monitor
    exp_t e;
    logic pcw;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() != 0) begin
        e   = q.pop_front();
        pcw = pc_write;
        @(posedge clk);
        #1;
        chk({e.nm, ".pcw"},   16'(pcw),          16'(e.pcw));
        chk({e.nm, ".instr"}, instr_out,         e.ins);
        chk({e.nm, ".pc"},    pc_plus2_out,      e.pc);
        chk({e.nm, ".valid"}, 16'(valid_out),    16'(e.v));
        chk({e.nm, ".rd"},    16'(IFID_RegRd),   16'(e.rd));
        chk({e.nm, ".rs"},    16'(IFID_RegRs),   16'(e.rs));
        chk({e.nm, ".rt"},    16'(IFID_RegRt),   16'(e.rt));
        chk({e.nm, ".halted"}, 16'(halted),      16'(e.h));
        pending--;
      end
    end
  end

  task automatic step(
    input logic s, input logic f,
    input logic [15:0] ii, input logic [15:0] pi,
    input logic [15:0] ei, input logic [15:0] ep, input logic ev,
    input logic [3:0] erd, input logic [3:0] ers, input logic [3:0] ert,
    input logic epcw, input logic eh, input string nm
  );
    exp_t e;
    @(negedge clk);
    stall       = s;
    flush       = f;
    instr_in    = ii;
    pc_plus2_in = pi;
    e = '{nm, ei, ep, ev, erd, ers, ert, epcw, eh};
    q.push_back(e);
    pending++;
  endtask

  task automatic drain();
    int n = 0;
    while (pending != 0 && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (pending != 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending=%0d want 0", pending);
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, ".instr"},  instr_out,       16'h0000);
    chk({nm, ".pc"},     pc_plus2_out,    16'h0000);
    chk({nm, ".valid"},  16'(valid_out),  16'h0);
    chk({nm, ".rd"},     16'(IFID_RegRd), 16'h0);
    chk({nm, ".halted"}, 16'(halted),     16'h0);
    chk({nm, ".pcw"},    16'(pc_write),   16'h1);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    rst = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    instr_in = 16'h0000;
    pc_plus2_in = 16'h0000;
    #12;
    chk_reset("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // s f  instr    pc       exp_ins  exp_pc   v rd    rs    rt    pcw h
    step(0, 0, 16'h2345, 16'h0012, 16'h2345, 16'h0012, 1, 4'h3, 4'h4, 4'h5, 1, 0, "t1_load");
    step(0, 0, 16'h1111, 16'h0020, 16'h1111, 16'h0020, 1, 4'h1, 4'h1, 4'h1, 1, 0, "t2_load");
    step(1, 0, 16'h7777, 16'h0022, 16'h1111, 16'h0020, 1, 4'h1, 4'h1, 4'h1, 0, 0, "t2_stall1");
    step(1, 0, 16'h7777, 16'h0022, 16'h1111, 16'h0020, 1, 4'h1, 4'h1, 4'h1, 0, 0, "t2_stall2");
    step(0, 0, 16'h7777, 16'h0022, 16'h7777, 16'h0022, 1, 4'h7, 4'h7, 4'h7, 1, 0, "t2_resume");
    step(1, 1, 16'h5555, 16'h0024, 16'h0000, 16'h0000, 0, 4'h0, 4'h0, 4'h0, 0, 0, "t3_flush_stall");
    step(0, 0, 16'h9A3C, 16'h0026, 16'h9A3C, 16'h0026, 1, 4'hA, 4'h3, 4'hA, 1, 0, "t3_sw");
    step(0, 0, 16'hA7B2, 16'h0028, 16'hA7B2, 16'h0028, 1, 4'h7, 4'h7, 4'h2, 1, 0, "t3_llb");
    step(0, 0, 16'hF000, 16'h0030, 16'hF000, 16'h0030, 1, 4'h0, 4'h0, 4'h0, 0, 0, "t5_hlt");
    step(0, 1, 16'h1234, 16'h0032, 16'h0000, 16'h0000, 0, 4'h0, 4'h0, 4'h0, 0, 0, "t5_flush");
    step(0, 0, 16'h1234, 16'h0032, 16'h1234, 16'h0032, 1, 4'h2, 4'h3, 4'h4, 1, 0, "t5_run");
    step(0, 0, 16'hF123, 16'h0040, 16'hF123, 16'h0040, 1, 4'h1, 4'h2, 4'h3, 0, 0, "t4_hlt");
    step(0, 0, 16'h1111, 16'h0042, 16'hF123, 16'h0040, 1, 4'h1, 4'h2, 4'h3, 0, 0, "t4_d1");
    step(1, 0, 16'h1111, 16'h0042, 16'hF123, 16'h0040, 1, 4'h1, 4'h2, 4'h3, 0, 0, "t4_d2");
    step(0, 0, 16'h1111, 16'h0042, 16'hF123, 16'h0040, 1, 4'h1, 4'h2, 4'h3, 0, 1, "t4_d3");
    step(1, 1, 16'h1111, 16'h0042, 16'hF123, 16'h0040, 1, 4'h1, 4'h2, 4'h3, 0, 1, "t4_flush_ign");
    step(0, 0, 16'h2222, 16'h0044, 16'hF123, 16'h0040, 1, 4'h1, 4'h2, 4'h3, 0, 1, "t4_absorb");
    drain();

    // Asynchronous reset out of HALTED, between clock edges.
    @(negedge clk);
    stall = 1'b0;
    flush = 1'b0;
    instr_in = 16'h0000;
    #2 rst = 1'b1;
    #1 chk_reset("t6_rst_halted");
    @(posedge clk);
    #1 rst = 1'b0;

    step(0, 0, 16'hF000, 16'h0050, 16'hF000, 16'h0050, 1, 4'h0, 4'h0, 4'h0, 0, 0, "t6_hlt");
    step(0, 0, 16'h0000, 16'h0052, 16'hF000, 16'h0050, 1, 4'h0, 4'h0, 4'h0, 0, 0, "t6_drain");
    drain();
    #1 rst = 1'b1;
    #1 chk_reset("t6_rst_drain");
    @(posedge clk);
    #1 rst = 1'b0;

    step(0, 0, 16'h1234, 16'h0060, 16'h1234, 16'h0060, 1, 4'h2, 4'h3, 4'h4, 1, 0, "p_load1");
    step(0, 0, 16'hA5C6, 16'h0062, 16'hA5C6, 16'h0062, 1, 4'h5, 4'h5, 4'h6, 1, 0, "p_load2");
    step(1, 0, 16'h1111, 16'h0064, 16'hA5C6, 16'h0062, 1, 4'h5, 4'h5, 4'h6, 0, 0, "p_stall1");
    step(1, 0, 16'h1111, 16'h0064, 16'hA5C6, 16'h0062, 1, 4'h5, 4'h5, 4'h6, 0, 0, "p_stall2");
    step(0, 1, 16'h2222, 16'h0066, 16'h0000, 16'h0000, 0, 4'h0, 4'h0, 4'h0, 1, 0, "p_flush");
    step(0, 0, 16'hB321, 16'h0068, 16'hB321, 16'h0068, 1, 4'h3, 4'h3, 4'h1, 1, 0, "p_lhb");
    drain();
`ifdef IFID_PERF_CNT_EN
    chk("perf.instr", instr_count, 16'd3);
    chk("perf.stall", stall_count, 16'd2);
    chk("perf.flush", flush_count, 16'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
